// File: rtl/btn_pkg.sv
// ============================================================================
// Module   : btn_pkg
// Purpose  : Shared types and defaults for the button auto-repeat front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int SAMPLE_DIV_50M   = 500000;
    localparam int REPEAT_DELAY_DEF = 50;
    localparam int REPEAT_RATE_DEF  = 10;
    localparam int ACCEL_AFTER      = 8;

    localparam int BTN_CLR = 0;
    localparam int BTN_MIN = 1;
    localparam int BTN_SEC = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_chan.sv
// ============================================================================
// Module   : btn_chan
// Purpose  : One button channel: synchroniser, 2-sample debounce, press and
//            auto-repeat FSM. Optional macro: BTN_REPEAT_ACCEL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_chan
    import btn_pkg::*;
#(
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter bit REPEAT_EN    = 1'b1
)(
    input  logic clk,
    input  logic rst,
    input  logic nbin,
    input  logic tick,
    output logic bout,
    output logic level
);

    localparam int CNT_W = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [CNT_W:0] DELAY_C = (CNT_W+1)'(REPEAT_DELAY);
    localparam logic [CNT_W:0] RATE_C  = (CNT_W+1)'(REPEAT_RATE);

    logic [1:0]       sync;
    logic [1:0]       hist;
    logic [1:0]       hist_nxt;
    logic             press_s;
    btn_state_t       state;
    btn_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   interval;
    logic             bout_nxt;

    assign press_s  = sync[1];
    assign hist_nxt = {hist[0], press_s};
    assign cnt_inc  = {1'b0, cnt} + 1'b1;

    // LEVEL only moves on two agreeing samples, so sub-tick glitches never reach it
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b00;
            hist  <= 2'b00;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], ~nbin};
            if (tick) begin
                hist <= hist_nxt;
                if (hist_nxt == 2'b11)
                    level <= 1'b1;
                else if (hist_nxt == 2'b00)
                    level <= 1'b0;
            end
        end
    end

`ifdef BTN_REPEAT_ACCEL_EN
    localparam logic [CNT_W:0] FAST_C =
        (CNT_W+1)'((REPEAT_RATE / 2 < 1) ? 1 : REPEAT_RATE / 2);
    logic [3:0] accel_cnt;

    // the pulse that enters REPEAT counts as the first repeat
    always_ff @(posedge clk) begin
        if (rst)
            accel_cnt <= 4'd0;
        else if (state_nxt != REPEAT)
            accel_cnt <= 4'd0;
        else if (bout_nxt && accel_cnt != 4'(ACCEL_AFTER))
            accel_cnt <= accel_cnt + 4'd1;
    end

    assign interval = (accel_cnt == 4'(ACCEL_AFTER)) ? FAST_C : RATE_C;
`else
    assign interval = RATE_C;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            bout  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            bout  <= bout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state != IDLE && !level) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (level) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end
                end
                HELD: begin
                    if (tick) begin
                        if (cnt_inc >= DELAY_C) begin
                            if (REPEAT_EN) begin
                                state_nxt = REPEAT;
                                cnt_nxt   = '0;
                            end else begin
                                cnt_nxt = DELAY_C[CNT_W-1:0];
                            end
                        end else begin
                            cnt_nxt = cnt_inc[CNT_W-1:0];
                        end
                    end
                end
                REPEAT: begin
                    if (tick) begin
                        if (cnt_inc >= interval)
                            cnt_nxt = '0;
                        else
                            cnt_nxt = cnt_inc[CNT_W-1:0];
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        bout_nxt = 1'b0;
        case (state)
            IDLE:    bout_nxt = level;
            HELD:    bout_nxt = level && tick && (cnt_inc >= DELAY_C) && REPEAT_EN;
            REPEAT:  bout_nxt = level && tick && (cnt_inc >= interval);
            default: bout_nxt = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/btn_autorepeat.sv
// ============================================================================
// Module   : btn_autorepeat
// Purpose  : N_BTN debounced push buttons with press and auto-repeat pulses,
//            sharing one sample-tick divider. Optional macro:
//            BTN_REPEAT_ACCEL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_autorepeat
    import btn_pkg::*;
#(
    parameter int               N_BTN        = 3,
    parameter int               SAMPLE_DIV   = SAMPLE_DIV_50M,
    parameter int               REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int               REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter logic [N_BTN-1:0] REPEAT_MASK  = 3'b110
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] nBIN,
    output logic [N_BTN-1:0] BOUT,
    output logic [N_BTN-1:0] LEVEL,
    output logic             TICK
);

    localparam int               DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0] div;

    always_ff @(posedge CLK) begin
        if (RST)
            div <= '0;
        else if (div == DIV_LAST)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    assign TICK = (div == DIV_LAST);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_chan #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_chan (
            .clk   (CLK),
            .rst   (RST),
            .nbin  (nBIN[i]),
            .tick  (TICK),
            .bout  (BOUT[i]),
            .level (LEVEL[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_btn_autorepeat.sv
// ============================================================================
// Module   : tb_btn_autorepeat
// Purpose  : Scoreboard bench for btn_autorepeat; expected pulse tick indices
//            are queued per channel when buttons are driven.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_autorepeat;
    import btn_pkg::*;

    localparam int         SDIV = 4;
    localparam int         DLY  = 3;
    localparam int         RATE = 2;
    localparam logic [2:0] MASK = 3'b110;

    logic       CLK  = 1'b0;
    logic       RST  = 1'b1;
    logic [2:0] nBIN = 3'b111;
    logic [2:0] BOUT;
    logic [2:0] LEVEL;
    logic       TICK;

    int         n_checks = 0;
    int         n_errors = 0;
    int         tick_cnt = 0;
    int         exp_q [3][$];
    logic [2:0] prev_bout = 3'b000;

    btn_autorepeat #(
        .N_BTN        (3),
        .SAMPLE_DIV   (SDIV),
        .REPEAT_DELAY (DLY),
        .REPEAT_RATE  (RATE),
        .REPEAT_MASK  (MASK)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .nBIN  (nBIN),
        .BOUT  (BOUT),
        .LEVEL (LEVEL),
        .TICK  (TICK)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Each pulse is tagged with the number of ticks seen so far.
    always @(negedge CLK) begin : mon
        int cur;
        cur = tick_cnt + ((TICK === 1'b1) ? 1 : 0);
        tick_cnt <= cur;
        for (int ch = 0; ch < 3; ch++) begin
            if (BOUT[ch] === 1'b1) begin
                check_val($sformatf("bout%0d_width", ch), int'(prev_bout[ch]), 0);
                if (exp_q[ch].size() == 0)
                    check_val($sformatf("bout%0d_unexpected_at_tick", ch), cur, -1);
                else
                    check_val($sformatf("bout%0d_tick", ch), cur, exp_q[ch].pop_front());
            end
        end
        prev_bout <= BOUT;
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (TICK !== 1'b1 && n < 3 * SDIV);
        if (TICK !== 1'b1)
            check_val("tick_timeout", 0, 1);
        #1;
    endtask

    // Press driven just after tick k0, release just after tick k1.
    task automatic push_hold(input int ch, input int k0, input int k1);
        int         t;
        int         n;
        int         gap;
        logic [2:0] m;
        m = MASK;
        t = k0 + 2;
        exp_q[ch].push_back(t);
        if (m[ch]) begin
            t = t + DLY;
            n = 0;
            while (t <= k1 + 2) begin
                exp_q[ch].push_back(t);
                n++;
                gap = RATE;
`ifdef BTN_REPEAT_ACCEL_EN
                if (n >= ACCEL_AFTER)
                    gap = (RATE / 2 < 1) ? 1 : RATE / 2;
`endif
                t = t + gap;
            end
        end
    endtask

    task automatic drain_check(input string tag);
        for (int ch = 0; ch < 3; ch++)
            check_val($sformatf("%s_missing_ch%0d", tag, ch), exp_q[ch].size(), 0);
        check_val($sformatf("%s_level_released", tag), int'(LEVEL), 0);
    endtask

    task automatic hold_buttons(input string tag, input logic [2:0] btns, input int nticks);
        int k0;
        wait_tick();
        k0 = tick_cnt;
        for (int ch = 0; ch < 3; ch++)
            if (btns[ch]) push_hold(ch, k0, k0 + nticks);
        nBIN = nBIN & ~btns;
        for (int i = 0; i < nticks; i++) begin
            wait_tick();
            if (i == 2)
                check_val($sformatf("%s_level_rise", tag), int'(LEVEL & btns), int'(btns));
        end
        nBIN = nBIN | btns;
        repeat (4) wait_tick();
        drain_check(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ticks;
        int last;
        int bad;
        int k0;
        int kr;
        int k1;

        // reset and idle
        repeat (4) @(negedge CLK);
        check_val("rst_bout", int'(BOUT), 0);
        check_val("rst_level", int'(LEVEL), 0);
        check_val("rst_tick", int'(TICK), 0);
        RST   = 1'b0;
        ticks = 0;
        last  = -1;
        bad   = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (TICK === 1'b1) begin
                ticks++;
                if (last >= 0)
                    check_val("tick_period", c - last, SDIV);
                last = c;
            end
            if (BOUT !== 3'b000 || LEVEL !== 3'b000)
                bad++;
        end
        check_val("idle_tick_count", ticks, 25);
        check_val("idle_outputs_nonzero", bad, 0);

        // chatter on channel 2 then a clean hold, released before any repeat
        wait_tick();
        k0 = tick_cnt;
        exp_q[2].push_back(k0 + 2);
        for (int i = 0; i < 6; i++) begin
            nBIN[2] = i[0];
            @(negedge CLK);
            #1;
        end
        nBIN[2] = 1'b0;
        wait_tick();
        check_val("chatter_level_before", int'(LEVEL[2]), 0);
        @(negedge CLK);
        #1;
        check_val("chatter_level_rise", int'(LEVEL[2]), 1);
        nBIN[2] = 1'b1;
        repeat (4) wait_tick();
        drain_check("chatter");

        // a one-clock glitch caught by a single sample must not debounce
        wait_tick();
        @(negedge CLK);
        @(negedge CLK);
        #1;
        nBIN[1] = 1'b0;
        @(negedge CLK);
        #1;
        nBIN[1] = 1'b1;
        repeat (3) wait_tick();
        check_val("glitch_level", int'(LEVEL[1]), 0);

        hold_buttons("repeat_min", 3'b010, 20);
        hold_buttons("norepeat_clr", 3'b001, 20);

        // simultaneous press, reset mid-hold, press re-detected afterwards
        wait_tick();
        k0 = tick_cnt;
        kr = k0 + 10;
        push_hold(2, k0, kr - 3);
        push_hold(1, k0, kr - 3);
        nBIN = nBIN & 3'b001;
        repeat (10) wait_tick();
        RST = 1'b1;
        k1  = kr + 12;
        @(negedge CLK);
        #1;
        check_val("midrst_bout", int'(BOUT), 0);
        check_val("midrst_level", int'(LEVEL), 0);
        check_val("midrst_tick", int'(TICK), 0);
        check_val("midrst_pre_pulses_left", exp_q[1].size() + exp_q[2].size(), 0);
        push_hold(2, kr, k1);
        push_hold(1, kr, k1);
        RST = 1'b0;
        repeat (12) wait_tick();
        nBIN = 3'b111;
        repeat (4) wait_tick();
        drain_check("midrst");

`ifdef BTN_REPEAT_ACCEL_EN
        hold_buttons("accel_sec", 3'b100, 40);
`endif

        repeat (4) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
